s2p_receiver: RTL

S2P_RECEIVER -- requirements
Module: s2p_receiver

---
 rtl/s2p_receiver_pkg.sv | 11 +
 rtl/s2p_bitcnt.sv | 36 +++
 rtl/s2p_receiver.sv | 95 +++++++++
 3 files changed

// File: rtl/s2p_receiver_pkg.sv
// Shared constants and helpers for the serial-to-parallel receiver.
package s2p_receiver_pkg;

  localparam int unsigned DefaultWidth = 4;

  // Bit-counter width for an N-bit frame: ceil(log2(N)), never less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/s2p_bitcnt.sv
// Frame bit counter: counts accepted bits 0..N-1, wraps, flags the last bit of a frame.
module s2p_bitcnt #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s2p_receiver.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready output slot
// and a sticky overrun flag for words dropped while the slot was occupied.
module s2p_receiver
  import s2p_receiver_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         w,
  input  logic         En,
  input  logic         Clr,
  input  logic         Ready,
  output logic [N-1:0] Q,
  output logic         Valid,
  output logic         Overrun,
  output logic         Busy
);

  localparam int unsigned CW = cnt_width(N);

  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  q_q, q_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          accept;
  logic          complete;
  logic          slot_free;
  logic [N-1:0]  word;

  s2p_bitcnt #(
    .N  (N),
    .CW (CW)
  ) u_bitcnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en_i   (En),
    .clr_i  (Clr),
    .cnt_o  (cnt),
    .last_o (last_bit)
  );

  // Clr takes priority over En: a bit arriving with Clr is dropped.
  assign accept    = En & ~Clr;
  assign complete  = accept & last_bit;
  assign slot_free = ~valid_q | Ready;
  assign word      = {w, s_q[N-1:1]};

  always_comb begin
    s_d       = s_q;
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (Clr) begin
      s_d       = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      s_d = word;
    end

    if (complete) begin
      if (slot_free) begin
        q_d     = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s_q       <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign Q       = q_q;
  assign Valid   = valid_q;
  assign Overrun = overrun_q;
  assign Busy    = (cnt != '0);

endmodule
